// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Optional build macro MDU_MADD_EN enables the MADD/MADDU opcodes in iter_mul_div.
package mdu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
  localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
  localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
  localparam logic [OP_W-1:0] OP_MADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_MADDU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_signed(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_madd(input logic [OP_W-1:0] op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Two's-complement sign correction: passes a magnitude through or negates it.
// Also used in reverse to take the magnitude of a negative operand.
module mdu_sign_fix #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] mag,
  input  logic         neg,
  output logic [N-1:0] val_c
);

  assign val_c = neg ? ((~mag) + N'(1)) : mag;

endmodule

// File: rtl/iter_mul_div.sv
// Multi-cycle radix-2 multiply/divide unit with architectural HI/LO registers.
// Build macro MDU_MADD_EN: enables MADD/MADDU accumulate into {hi,lo}; otherwise those ops are illegal.
module iter_mul_div
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned W2    = 2 * WIDTH;

  state_t           state;
  logic [2:0]       op_q;
  logic             sa_q;
  logic             sb_q;
  logic             dz_q;
  logic [WIDTH-1:0] ma_q;
  logic [WIDTH-1:0] mb_q;
  logic [W2-1:0]    acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             op_legal_c;
  logic             sa_in_c;
  logic             sb_in_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   div_shift_c;
  logic [WIDTH:0]   div_diff_c;
  logic [W2-1:0]    mul_next_c;
  logic [W2-1:0]    div_next_c;
  logic [W2-1:0]    prod_c;
  logic [WIDTH-1:0] quot_c;
  logic [WIDTH-1:0] rem_c;

`ifdef MDU_MADD_EN
  assign op_legal_c = (op <= OP_MADDU);
`else
  assign op_legal_c = (op <= OP_DIVU);
`endif

  assign sa_in_c = is_signed(op) & a[WIDTH-1];
  assign sb_in_c = is_signed(op) & b[WIDTH-1];

  // Operand magnitudes taken at the input boundary
  mdu_sign_fix #(.N(WIDTH)) u_mag_a (.mag(a), .neg(sa_in_c), .val_c(a_mag_c));
  mdu_sign_fix #(.N(WIDTH)) u_mag_b (.mag(b), .neg(sb_in_c), .val_c(b_mag_c));

  // Shift-add step: accumulator upper half gains the multiplicand when the current multiplier bit is set
  assign mul_sum_c  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? ma_q : {WIDTH{1'b0}})};
  assign mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};

  // Restoring step: upper half is the partial remainder, lower half shifts dividend out and quotient in
  assign div_shift_c = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff_c  = div_shift_c - {1'b0, mb_q};
  assign div_next_c  = div_diff_c[WIDTH]
                     ? {div_shift_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_diff_c[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  mdu_sign_fix #(.N(W2))    u_fix_prod (.mag(acc_q),              .neg(sa_q ^ sb_q), .val_c(prod_c));
  mdu_sign_fix #(.N(WIDTH)) u_fix_quot (.mag(acc_q[WIDTH-1:0]),   .neg(sa_q ^ sb_q), .val_c(quot_c));
  mdu_sign_fix #(.N(WIDTH)) u_fix_rem  (.mag(acc_q[W2-1:WIDTH]),  .neg(sa_q),        .val_c(rem_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= OP_MULT;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
      ma_q  <= '0;
      mb_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && op_legal_c && !flush) begin
            op_q  <= op;
            sa_q  <= sa_in_c;
            sb_q  <= sb_in_c;
            ma_q  <= a_mag_c;
            mb_q  <= b_mag_c;
            busy  <= 1'b1;
            if (is_div(op) && (b == '0)) begin
              // Divide by zero bypasses the iteration; result is preformatted in the accumulator
              dz_q  <= 1'b1;
              acc_q <= {a, {WIDTH{1'b1}}};
              cnt_q <= '0;
              state <= ST_FIX;
            end else begin
              dz_q  <= 1'b0;
              acc_q <= is_div(op) ? {{WIDTH{1'b0}}, a_mag_c} : {{WIDTH{1'b0}}, b_mag_c};
              cnt_q <= CNT_W'(WIDTH);
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt_q <= '0;
          end else begin
            acc_q <= is_div(op_q) ? div_next_c : mul_next_c;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (dz_q) begin
              hi <= acc_q[W2-1:WIDTH];
              lo <= acc_q[WIDTH-1:0];
            end else if (is_div(op_q)) begin
              hi <= rem_c;
              lo <= quot_c;
`ifdef MDU_MADD_EN
            end else if (is_madd(op_q)) begin
              {hi, lo} <= {hi, lo} + prod_c;
`endif
            end else begin
              {hi, lo} <= prod_c;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
